debug_ram_arbiter: RTL and testbench

//  Owns the single port of the 1K x 8 debug RAM and shares it between three users:
//  the VGA binary display reader (fixed 1-cycle read latency, absolute priority),
//  an internal clear/fill sequencer, and one general client (CA engine / debug writer).

---
 rtl/debug_ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_debug_ram_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_ram_arbiter.sv
// debug_ram_arbiter
//   Owns the single port of the debug RAM and shares it between the VGA
//   display reader (absolute priority, fixed 1-cycle read latency), an
//   internal clear/fill sequencer and one general client.
//
// Ports
//   clk, rst            pixel clock; asynchronous active-high reset
//   disp_rd/disp_addr   display read request and address
//   disp_data           display read data, valid the cycle after disp_rd
//   cli_req/cli_we/cli_addr/cli_wdata   client request, held until granted
//   cli_gnt             client access performed this cycle
//   cli_rvalid          one-cycle pulse, two cycles after a client read grant
//   cli_rdata           client read data, held until the next client read
//   clr_start/clr_value start a whole-RAM fill with clr_value
//   clr_busy/clr_done   fill in progress / one-cycle pulse after last write
//   starved             sticky: client waited MAX_WAIT cycles or more
//   ram_*               RAM port (synchronous read, 1-cycle latency)
//   dbg_state           current FSM state (1 = CLEAR), for observation only
//
// Client handshake: a transfer happens in every cycle with cli_req & cli_gnt.
// While cli_req & !cli_gnt the client keeps cli_we/cli_addr/cli_wdata stable.
// Grants may occur on consecutive cycles.

module debug_ram_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 2048
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_rd,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  input  logic          cli_req,
  input  logic          cli_we,
  input  logic [AW-1:0] cli_addr,
  input  logic [DW-1:0] cli_wdata,
  output logic          cli_gnt,
  output logic          cli_rvalid,
  output logic [DW-1:0] cli_rdata,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_value,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          starved,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          dbg_state
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic [DW-1:0] clr_value_q;
  logic          clr_slot;
  logic          rd_pend;
  logic [CW-1:0] wait_cnt;

  assign dbg_state = (state == ST_CLEAR);

  // The display path is a straight pass-through so its latency is exactly
  // the RAM's own one cycle.
  assign disp_data = ram_rdata;

  // Slot owner, decided combinationally every cycle:
  //   display > clear sequencer > client > idle.
  // rst is included so nothing is granted or written while reset is held.
  always_comb begin
    cli_gnt   = 1'b0;
    clr_slot  = 1'b0;
    ram_addr  = disp_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (!rst) begin
      if (disp_rd) begin
        ram_addr = disp_addr;
      end else if (state == ST_CLEAR) begin
        clr_slot  = 1'b1;
        ram_addr  = clr_ptr;
        ram_we    = 1'b1;
        ram_wdata = clr_value_q;
      end else if (cli_req) begin
        cli_gnt   = 1'b1;
        ram_addr  = cli_addr;
        ram_we    = cli_we;
        ram_wdata = cli_wdata;
      end
    end
  end

  // Clear/fill sequencer. The pointer only advances on cycles that actually
  // own the slot, so display reads simply stretch the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      clr_ptr     <= '0;
      clr_value_q <= '0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state       <= ST_CLEAR;
            clr_value_q <= clr_value;
            clr_ptr     <= '0;
            clr_busy    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_slot) begin
            if (&clr_ptr) begin
              state    <= ST_IDLE;
              clr_ptr  <= '0;
              clr_busy <= 1'b0;
              clr_done <= 1'b1;
            end else begin
              clr_ptr <= clr_ptr + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Client read return: grant in t, RAM data appears in t+1 and is captured
  // at the end of t+1, so the pulse lands in t+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend    <= 1'b0;
      cli_rvalid <= 1'b0;
      cli_rdata  <= '0;
    end else begin
      rd_pend    <= cli_gnt & ~cli_we;
      cli_rvalid <= rd_pend;
      if (rd_pend) begin
        cli_rdata <= ram_rdata;
      end
    end
  end

  // Starvation monitor: counts consecutive refused cycles. starved rises at
  // the end of the MAX_WAIT-th refused cycle and stays until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      starved  <= 1'b0;
    end else if (cli_req && !cli_gnt) begin
      if (wait_cnt != CW'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_cnt >= CW'(MAX_WAIT - 1)) begin
        starved <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_debug_ram_arbiter.sv
// Bench for debug_ram_arbiter: drives the arbiter against a behavioural
// synchronous RAM, and compares against a shadow memory plus queues of
// expected client read returns.

module tb_debug_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int MAX_WAIT = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          disp_rd;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          cli_req;
  logic          cli_we;
  logic [AW-1:0] cli_addr;
  logic [DW-1:0] cli_wdata;
  logic          cli_gnt;
  logic          cli_rvalid;
  logic [DW-1:0] cli_rdata;
  logic          clr_start;
  logic [DW-1:0] clr_value;
  logic          clr_busy;
  logic          clr_done;
  logic          starved;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          dbg_state;

  int total;
  int bad;

  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] exp_mem [0:DEPTH-1];
  logic [DW-1:0] exp_q[$];
  int            due_q[$];

  debug_ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .disp_rd(disp_rd), .disp_addr(disp_addr), .disp_data(disp_data),
    .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_wdata(cli_wdata),
    .cli_gnt(cli_gnt), .cli_rvalid(cli_rvalid), .cli_rdata(cli_rdata),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
    .clr_done(clr_done), .starved(starved),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural synchronous RAM, read-before-write
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic client_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    disp_rd = 1'b0; cli_req = 1'b1; cli_we = 1'b1; cli_addr = a; cli_wdata = d;
    @(posedge clk); #1;
    cli_req = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1; cli_req = 1'b1; cli_we = 1'b1; cli_addr = 10'h055; cli_wdata = 8'h11;
    disp_rd = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cli_gnt !== 1'b0 || ram_we !== 1'b0) begin
      bad++; $display("FAIL reset_gate: gnt=%0b we=%0b want 0 0", cli_gnt, ram_we);
    end
    total++;
    if ({clr_busy, clr_done, starved, cli_rvalid, dbg_state} !== 5'b0 || cli_rdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: busy=%0b done=%0b starved=%0b rvalid=%0b state=%0b rdata=%h want all 0",
               clr_busy, clr_done, starved, cli_rvalid, dbg_state, cli_rdata);
    end
    cli_req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_client_rw();
    disp_rd = 1'b0; cli_req = 1'b1; cli_we = 1'b1; cli_addr = 10'h3FF; cli_wdata = 8'hA5;
    #1;
    total++;
    if (cli_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'h3FF || ram_wdata !== 8'hA5) begin
      bad++;
      $display("FAIL client_write: gnt=%0b we=%0b addr=%h wdata=%h want 1 1 3ff a5",
               cli_gnt, ram_we, ram_addr, ram_wdata);
    end
    exp_mem[10'h3FF] = 8'hA5;
    @(posedge clk); #1;
    cli_we = 1'b0; #1;
    total++;
    if (cli_gnt !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 10'h3FF) begin
      bad++; $display("FAIL client_read_grant: gnt=%0b we=%0b addr=%h want 1 0 3ff", cli_gnt, ram_we, ram_addr);
    end
    @(posedge clk); #1;
    cli_req = 1'b0;
    total++;
    if (cli_rvalid !== 1'b0) begin
      bad++; $display("FAIL rvalid_early: rvalid=%0b want 0", cli_rvalid);
    end
    @(posedge clk); #1;
    total++;
    if (cli_rvalid !== 1'b1 || cli_rdata !== 8'hA5) begin
      bad++; $display("FAIL rvalid_pulse: rvalid=%0b rdata=%h want 1 a5", cli_rvalid, cli_rdata);
    end
    @(posedge clk); #1;
    total++;
    if (cli_rvalid !== 1'b0 || cli_rdata !== 8'hA5) begin
      bad++; $display("FAIL rdata_hold: rvalid=%0b rdata=%h want 0 a5", cli_rvalid, cli_rdata);
    end
  endtask

  task automatic test_disp_priority();
    client_write(10'h05A, 8'hC3);
    disp_rd = 1'b1; disp_addr = 10'h05A; cli_req = 1'b1; cli_we = 1'b0; cli_addr = 10'h123;
    #1;
    total++;
    if (cli_gnt !== 1'b0 || ram_addr !== 10'h05A || ram_we !== 1'b0) begin
      bad++; $display("FAIL disp_priority: gnt=%0b addr=%h we=%0b want 0 05a 0", cli_gnt, ram_addr, ram_we);
    end
    @(posedge clk); #1;
    disp_rd = 1'b0; cli_req = 1'b0; #1;
    total++;
    if (disp_data !== 8'hC3) begin
      bad++; $display("FAIL disp_data: got=%h want c3", disp_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_disp_stall();
    logic [AW-1:0] exp_addr;
    client_write(10'h010, 8'h4B);
    cli_req = 1'b1; cli_we = 1'b0; cli_addr = 10'h010; disp_addr = 10'h0F0;
    for (int k = 0; k < 3; k++) begin
      disp_rd = (k < 2);
      #1;
      exp_addr = (k == 2) ? 10'h010 : 10'h0F0;
      total++;
      if (cli_gnt !== (k == 2) || ram_addr !== exp_addr) begin
        bad++; $display("FAIL disp_stall[%0d]: gnt=%0b addr=%h want %0b %h", k, cli_gnt, ram_addr, (k == 2), exp_addr);
      end
      @(posedge clk); #1;
    end
    cli_req = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cli_rvalid !== 1'b1 || cli_rdata !== 8'h4B) begin
      bad++; $display("FAIL stall_read: rvalid=%0b rdata=%h want 1 4b", cli_rvalid, cli_rdata);
    end
  endtask

  task automatic test_clear();
    int mw, busy_err, done_err, gnt_err, wr_err, mem_err;
    mw = 0; busy_err = 0; done_err = 0; gnt_err = 0; wr_err = 0; mem_err = 0;
    cli_req = 1'b0; disp_rd = 1'($urandom_range(0, 1));
    clr_start = 1'b1; clr_value = 8'h00;
    @(posedge clk); #1;
    clr_start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (clr_busy !== (mw < DEPTH) || dbg_state !== (mw < DEPTH)) busy_err++;
      if (clr_done !== (mw == DEPTH)) done_err++;
      if (mw == DEPTH) break;
      disp_rd = 1'($urandom_range(0, 1));
      disp_addr = AW'($urandom_range(0, DEPTH - 1));
      cli_req = 1'b1; cli_we = 1'b1; cli_addr = AW'($urandom_range(0, DEPTH - 1)); cli_wdata = 8'hFF;
      #1;
      if (cli_gnt !== 1'b0) gnt_err++;
      if (!disp_rd) begin
        if (ram_we !== 1'b1 || ram_addr !== AW'(mw) || ram_wdata !== 8'h00) wr_err++;
        mw++;
      end else if (ram_we !== 1'b0) begin
        wr_err++;
      end
      @(posedge clk); #1;
    end
    cli_req = 1'b0; disp_rd = 1'b0;
    @(posedge clk); #1;
    total++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      bad++; $display("FAIL clear_after: done=%0b busy=%0b want 0 0", clr_done, clr_busy);
    end
    total++;
    if (mw != DEPTH || wr_err != 0) begin
      bad++; $display("FAIL clear_writes: count=%0d bad_writes=%0d want %0d 0", mw, wr_err, DEPTH);
    end
    total++;
    if (busy_err != 0 || done_err != 0) begin
      bad++; $display("FAIL clear_flags: busy_err=%0d done_err=%0d want 0 0", busy_err, done_err);
    end
    total++;
    if (gnt_err != 0) begin
      bad++; $display("FAIL clear_no_grant: grants=%0d want 0", gnt_err);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== 8'h00) mem_err++;
      exp_mem[i] = 8'h00;
    end
    total++;
    if (mem_err != 0) begin
      bad++; $display("FAIL clear_contents: nonzero=%0d want 0", mem_err);
    end
  endtask

  task automatic test_random_traffic();
    localparam int N = 400;
    logic pend, exp_gnt, prev_disp, have_last;
    logic [DW-1:0] prev_exp, last_rd;
    logic [AW-1:0] exp_addr;
    pend = 1'b0; prev_disp = 1'b0; have_last = 1'b0; prev_exp = '0; last_rd = '0;
    exp_q.delete(); due_q.delete();
    for (int i = 0; i < N + 3; i++) begin
      if (!pend) begin
        cli_req   = (i < N) ? ($urandom_range(0, 3) != 0) : 1'b0;
        cli_we    = 1'($urandom_range(0, 1));
        cli_addr  = AW'($urandom_range(0, 31));
        cli_wdata = DW'($urandom_range(0, 255));
      end
      disp_rd   = (i < N) ? 1'($urandom_range(0, 1)) : 1'b0;
      disp_addr = AW'($urandom_range(0, 31));
      #1;
      exp_gnt  = cli_req && !disp_rd;
      exp_addr = exp_gnt ? cli_addr : disp_addr;
      total++;
      if (cli_gnt !== exp_gnt || ram_we !== (exp_gnt && cli_we) || ram_addr !== exp_addr) begin
        bad++;
        $display("FAIL rand_slot[%0d]: gnt=%0b we=%0b addr=%h want %0b %0b %h",
                 i, cli_gnt, ram_we, ram_addr, exp_gnt, exp_gnt && cli_we, exp_addr);
      end
      if (due_q.size() > 0 && due_q[0] == i) begin
        total++;
        if (cli_rvalid !== 1'b1 || cli_rdata !== exp_q[0]) begin
          bad++; $display("FAIL rand_read[%0d]: rvalid=%0b rdata=%h want 1 %h", i, cli_rvalid, cli_rdata, exp_q[0]);
        end
        last_rd = exp_q[0]; have_last = 1'b1;
        void'(exp_q.pop_front()); void'(due_q.pop_front());
      end else begin
        total++;
        if (cli_rvalid !== 1'b0 || (have_last && cli_rdata !== last_rd)) begin
          bad++; $display("FAIL rand_idle[%0d]: rvalid=%0b rdata=%h want 0 %h", i, cli_rvalid, cli_rdata, last_rd);
        end
      end
      if (prev_disp) begin
        total++;
        if (disp_data !== prev_exp) begin
          bad++; $display("FAIL rand_disp[%0d]: got=%h want %h", i, disp_data, prev_exp);
        end
      end
      prev_disp = disp_rd;
      prev_exp  = exp_mem[disp_addr];
      if (exp_gnt) begin
        if (cli_we) begin
          exp_mem[cli_addr] = cli_wdata;
        end else begin
          exp_q.push_back(exp_mem[cli_addr]);
          due_q.push_back(i + 2);
        end
      end
      pend = cli_req && !exp_gnt;
      @(posedge clk); #1;
    end
    cli_req = 1'b0;
    total++;
    if (due_q.size() != 0) begin
      bad++; $display("FAIL rand_drain: outstanding=%0d want 0", due_q.size());
    end
  endtask

  task automatic test_starve();
    int st_err;
    st_err = 0;
    pulse_reset();
    disp_rd = 1'b1; disp_addr = 10'h001;
    cli_req = 1'b1; cli_we = 1'b1; cli_addr = 10'h2AA; cli_wdata = 8'h5A;
    for (int k = 0; k < 20; k++) begin
      if (starved !== (k >= MAX_WAIT)) st_err++;
      @(posedge clk); #1;
    end
    total++;
    if (st_err != 0) begin
      bad++; $display("FAIL starve_rise: mistimed_cycles=%0d want 0", st_err);
    end
    disp_rd = 1'b0; #1;
    total++;
    if (cli_gnt !== 1'b1 || starved !== 1'b1) begin
      bad++; $display("FAIL starve_grant: gnt=%0b starved=%0b want 1 1", cli_gnt, starved);
    end
    @(posedge clk); #1;
    cli_req = 1'b0;
    exp_mem[10'h2AA] = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (starved !== 1'b1) begin
      bad++; $display("FAIL starve_sticky: starved=%0b want 1", starved);
    end
    rst = 1'b1; #1;
    total++;
    if (starved !== 1'b0) begin
      bad++; $display("FAIL starve_reset: starved=%0b want 0", starved);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_clear();
    int a_err, done_seen, cnt, mem_err;
    a_err = 0; done_seen = 0; cnt = 0; mem_err = 0;
    disp_rd = 1'b0; cli_req = 1'b0;
    clr_start = 1'b1; clr_value = 8'h77;
    @(posedge clk); #1;
    clr_start = 1'b0;
    for (int n = 0; n < 'h200; n++) begin
      if (ram_we !== 1'b1 || ram_addr !== AW'(n)) a_err++;
      @(posedge clk); #1;
    end
    total++;
    if (a_err != 0 || ram_addr !== 10'h200) begin
      bad++; $display("FAIL mid_clear_ptr: bad_writes=%0d addr=%h want 0 200", a_err, ram_addr);
    end
    cli_req = 1'b1; cli_we = 1'b1; cli_addr = 10'h300;
    rst = 1'b1; #1;
    total++;
    if (clr_busy !== 1'b0 || ram_we !== 1'b0 || cli_gnt !== 1'b0) begin
      bad++; $display("FAIL mid_clear_rst: busy=%0b we=%0b gnt=%0b want 0 0 0", clr_busy, ram_we, cli_gnt);
    end
    @(posedge clk); #1;
    rst = 1'b0; cli_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) done_seen++;
      @(posedge clk); #1;
    end
    total++;
    if (done_seen != 0) begin
      bad++; $display("FAIL mid_clear_no_done: flagged_cycles=%0d want 0", done_seen);
    end
    for (int i = 0; i < 'h200; i++) exp_mem[i] = 8'h77;
    total++;
    if (mem[10'h1FF] !== exp_mem[10'h1FF] || mem[10'h200] !== exp_mem[10'h200]) begin
      bad++; $display("FAIL mid_clear_mem: m1ff=%h m200=%h want %h %h",
                      mem[10'h1FF], mem[10'h200], exp_mem[10'h1FF], exp_mem[10'h200]);
    end
    // reset between a read grant and its return
    cli_req = 1'b1; cli_we = 1'b0; cli_addr = 10'h005;
    @(posedge clk); #1;
    cli_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (cli_rvalid !== 1'b0 || cli_rdata !== 8'h00) done_seen++;
      @(posedge clk); #1;
    end
    total++;
    if (done_seen != 0) begin
      bad++; $display("FAIL mid_read_rst: bad_cycles=%0d want 0", done_seen);
    end
    // fresh fill must restart from address 0
    clr_start = 1'b1; clr_value = 8'h3C;
    @(posedge clk); #1;
    clr_start = 1'b0;
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 10'h000 || ram_wdata !== 8'h3C) begin
      bad++; $display("FAIL refill_start: we=%0b addr=%h wdata=%h want 1 000 3c", ram_we, ram_addr, ram_wdata);
    end
    done_seen = 0;
    for (int k = 0; k < 1100 && done_seen == 0; k++) begin
      @(posedge clk); #1;
      cnt++;
      if (clr_done === 1'b1) done_seen = 1;
    end
    total++;
    if (done_seen != 1 || cnt != DEPTH) begin
      bad++; $display("FAIL refill_done: done=%0d cycles=%0d want 1 %0d", done_seen, cnt, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== 8'h3C) mem_err++;
      exp_mem[i] = 8'h3C;
    end
    total++;
    if (mem_err != 0) begin
      bad++; $display("FAIL refill_contents: wrong_cells=%0d want 0", mem_err);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; disp_rd = 1'b0; disp_addr = '0;
    cli_req = 1'b0; cli_we = 1'b0; cli_addr = '0; cli_wdata = '0;
    clr_start = 1'b0; clr_value = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    test_reset();
    test_client_rw();
    test_disp_priority();
    test_disp_stall();
    test_clear();
    test_random_traffic();
    test_starve();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
